// File: rtl/axi4dma_rd_pkg.sv
// rtl/axi4dma_rd_pkg.sv - shared types and constants for the AXI4 DMA read burst controller
package axi4dma_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADDR,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [8:0] MAX_INCR_BEATS  = 9'd256;
    localparam logic [8:0] MAX_FIXED_BEATS = 9'd16;

    // SLVERR (10) and DECERR (11) both mark the request as failed
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

endpackage

// File: rtl/axi4dma_rd_burst_calc.sv
// rtl/axi4dma_rd_burst_calc.sv - beats of the next AR burst; 4 KB term under CORE_AXI4DMA_RD_4K_SPLIT_EN
module axi4dma_rd_burst_calc
    import axi4dma_rd_pkg::*;
(
    input  logic [23:0] remaining,
    input  logic        fixed,
`ifdef CORE_AXI4DMA_RD_4K_SPLIT_EN
    input  logic [11:0] addr_low,
    input  logic [2:0]  size,
`endif
    output logic [8:0]  burst_beats
);

    logic [8:0] rem_clamp;
`ifdef CORE_AXI4DMA_RD_4K_SPLIT_EN
    logic [12:0] page_beats;
`endif

    always_comb begin
        rem_clamp   = (remaining > 24'd256) ? MAX_INCR_BEATS : remaining[8:0];
        burst_beats = rem_clamp;
        if (fixed && (rem_clamp > MAX_FIXED_BEATS)) begin
            burst_beats = MAX_FIXED_BEATS;
        end
`ifdef CORE_AXI4DMA_RD_4K_SPLIT_EN
        // address is size-aligned, so at least one beat always fits before the boundary
        page_beats = (13'd4096 - {1'b0, addr_low}) >> size;
        if (!fixed && (page_beats < {4'd0, burst_beats})) begin
            burst_beats = page_beats[8:0];
        end
`endif
    end

endmodule

// File: rtl/axi4dma_rd_burst_ctrl.sv
// rtl/axi4dma_rd_burst_ctrl.sv - splits the queue-head read request into AR bursts; macro CORE_AXI4DMA_RD_4K_SPLIT_EN
module axi4dma_rd_burst_ctrl
    import axi4dma_rd_pkg::*;
#(
    parameter int MAX_TRAN_SIZE_WIDTH = 23,
    parameter int AXI_DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           reqInQueue,
    input  logic [31:0]                    srcAddr,
    input  logic [1:0]                     srcOp,
    input  logic [2:0]                     srcDataWidth,
    input  logic [MAX_TRAN_SIZE_WIDTH-1:0] numOfBytes,
    input  logic                           spaceWrTranQueue,
    output logic [31:0]                    ARADDR,
    output logic [7:0]                     ARLEN,
    output logic [2:0]                     ARSIZE,
    output logic [1:0]                     ARBURST,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    input  logic                           RVALID,
    input  logic                           RREADY,
    input  logic                           RLAST,
    input  logic [1:0]                     RRESP,
    output logic                           rdCache1Sel,
    output logic                           rdDone,
    output logic                           rdError,
    output logic                           busy
);

    localparam logic [31:0] MAX_SIZE  = 32'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [3:0]  OUT_LIMIT = 4'(MAX_OUTSTANDING);

    rd_state_t   state, state_nxt;
    logic [23:0] rem_beats;
    logic [3:0]  outstanding, out_nxt;
    logic        err_flag;
    logic [8:0]  burst_beats, cur_beats;
    logic [23:0] size_mask, total_beats;
    logic        start, illegal, zero_len;
    logic        ar_hs, r_beat, r_last_hs;

    axi4dma_rd_burst_calc u_calc (
        .remaining   (rem_beats),
        .fixed       (ARBURST == BURST_FIXED),
`ifdef CORE_AXI4DMA_RD_4K_SPLIT_EN
        .addr_low    (ARADDR[11:0]),
        .size        (ARSIZE),
`endif
        .burst_beats (burst_beats)
    );

    assign start     = reqInQueue & spaceWrTranQueue;
    assign ar_hs     = ARVALID & ARREADY;
    assign r_beat    = RVALID & RREADY;
    // RLAST with nothing outstanding belongs to a burst issued before reset
    assign r_last_hs = r_beat & RLAST & (outstanding != 4'd0);
    assign out_nxt   = outstanding + {3'd0, ar_hs} - {3'd0, r_last_hs};
    assign cur_beats = {1'b0, ARLEN} + 9'd1;

    always_comb begin
        size_mask   = (24'd1 << srcDataWidth) - 24'd1;
        total_beats = (24'(numOfBytes) + size_mask) >> srcDataWidth;
        zero_len    = (numOfBytes == '0);
        illegal     = srcOp[1] | ({29'd0, srcDataWidth} > MAX_SIZE)
                    | ((srcAddr & {8'd0, size_mask}) != 32'd0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (illegal || zero_len) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (ar_hs) begin
                    state_nxt = ((rem_beats != {15'd0, cur_beats}) && (out_nxt < OUT_LIMIT))
                              ? ST_CALC : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((rem_beats != 24'd0) && (out_nxt < OUT_LIMIT)) begin
                    state_nxt = ST_CALC;
                end else if ((rem_beats == 24'd0) && (out_nxt == 4'd0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ARADDR      <= 32'd0;
            ARLEN       <= 8'd0;
            ARSIZE      <= 3'd0;
            ARBURST     <= BURST_INCR;
            rem_beats   <= 24'd0;
            outstanding <= 4'd0;
            err_flag    <= 1'b0;
            rdCache1Sel <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ARADDR    <= srcAddr;
                        ARSIZE    <= srcDataWidth;
                        ARBURST   <= (srcOp == 2'b01) ? BURST_FIXED : BURST_INCR;
                        rem_beats <= zero_len ? 24'd0 : total_beats;
                        err_flag  <= illegal;
                    end
                end
                ST_CALC: ARLEN <= 8'(burst_beats - 9'd1);
                ST_ADDR: begin
                    if (ar_hs) begin
                        rem_beats <= rem_beats - {15'd0, cur_beats};
                        if (ARBURST == BURST_INCR) begin
                            ARADDR <= ARADDR + ({23'd0, cur_beats} << ARSIZE);
                        end
                    end
                end
                ST_DONE: rdCache1Sel <= ~rdCache1Sel;
                default: ;
            endcase
            if ((state != ST_IDLE) && r_beat && resp_is_error(RRESP)) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign ARVALID = (state == ST_ADDR);
    assign busy    = (state != ST_IDLE);
    assign rdDone  = (state == ST_DONE) & ~err_flag;
    assign rdError = (state == ST_DONE) & err_flag;

endmodule

// File: tb/tb_axi4dma_rd_burst_ctrl.sv
// tb/tb_axi4dma_rd_burst_ctrl.sv - randomized bench for axi4dma_rd_burst_ctrl with a burst-split reference model
module tb_axi4dma_rd_burst_ctrl;

    localparam int MAXO = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        reqInQueue, spaceWrTranQueue;
    logic [31:0] srcAddr;
    logic [1:0]  srcOp;
    logic [2:0]  srcDataWidth;
    logic [22:0] numOfBytes;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID, ARREADY;
    logic        RVALID, RREADY, RLAST;
    logic [1:0]  RRESP;
    logic        rdCache1Sel, rdDone, rdError, busy;

    int total = 0;
    int bad   = 0;

    logic [44:0] obs[$];
    logic [44:0] exp_q[$];
    int          pend[$];
    bit          exp_err;
    int          exp_beats;
    bit          exp_sel = 1'b0;
    int          beat_idx = 0;
    int          err_beat = -1;
    int          cur_beat = 0;
    int          ar_stall = 0;
    bit          r_hold = 1'b0;
    int          r_release = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    bit          last;

    always #5 clock = ~clock;

    axi4dma_rd_burst_ctrl #(
        .MAX_TRAN_SIZE_WIDTH (23),
        .AXI_DATA_WIDTH      (64),
        .MAX_OUTSTANDING     (MAXO)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .reqInQueue       (reqInQueue),
        .srcAddr          (srcAddr),
        .srcOp            (srcOp),
        .srcDataWidth     (srcDataWidth),
        .numOfBytes       (numOfBytes),
        .spaceWrTranQueue (spaceWrTranQueue),
        .ARADDR           (ARADDR),
        .ARLEN            (ARLEN),
        .ARSIZE           (ARSIZE),
        .ARBURST          (ARBURST),
        .ARVALID          (ARVALID),
        .ARREADY          (ARREADY),
        .RVALID           (RVALID),
        .RREADY           (RREADY),
        .RLAST            (RLAST),
        .RRESP            (RRESP),
        .rdCache1Sel      (rdCache1Sel),
        .rdDone           (rdDone),
        .rdError          (rdError),
        .busy             (busy)
    );

    // AR handshakes and outstanding bursts as seen on the bus
    always @(negedge clock) begin
        if (resetn && ARVALID && ARREADY) begin
            obs.push_back({ARADDR, ARLEN, ARSIZE, ARBURST});
            pend.push_back(int'(ARLEN));
            out_cnt++;
        end
        if (resetn && RVALID && RREADY && RLAST && out_cnt > 0) out_cnt--;
        if (out_cnt > max_out) max_out = out_cnt;
    end

    // In-order R slave with random gaps, optional RLAST withholding, and ARREADY driver
    initial begin
        RVALID = 0; RLAST = 0; RRESP = 0; RREADY = 1; ARREADY = 0;
        forever begin
            @(posedge clock); #1;
            if (RVALID && RREADY && resetn) begin
                beat_idx++;
                if (RLAST) begin
                    if (pend.size() > 0) void'(pend.pop_front());
                    cur_beat = 0;
                end else begin
                    cur_beat++;
                end
            end
            RVALID = 0; RLAST = 0; RRESP = 0;
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                last = (cur_beat == pend[0]);
                if (!(last && r_hold && r_release == 0)) begin
                    RVALID = 1;
                    RLAST  = last;
                    RRESP  = (beat_idx == err_beat) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
                    if (last && r_hold) r_release--;
                end
            end
            if (ar_stall > 0) begin
                ARREADY = 0;
                ar_stall--;
            end else begin
                ARREADY = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic start_req(input logic [31:0] a, input logic [1:0] op, input logic [2:0] sz,
                             input int nb, input int errb);
        int          bsz;
        int          rem;
        int          b;
        logic [63:0] cur;
        bit          ill;
        bsz = 1 << sz;
        cur = {32'd0, a};
        ill = op[1] || (sz > 3) || ((a % bsz) != 0);
        exp_q.delete();
        exp_beats = 0;
        if (!ill && nb > 0) begin
            rem = (nb + bsz - 1) / bsz;
            exp_beats = rem;
            while (rem > 0) begin
                b = (op == 2'b01) ? 16 : 256;
                if (rem < b) b = rem;
`ifdef CORE_AXI4DMA_RD_4K_SPLIT_EN
                if (op == 2'b00 && ((4096 - int'(cur % 4096)) / bsz) < b) b = (4096 - int'(cur % 4096)) / bsz;
`endif
                exp_q.push_back({cur[31:0], 8'(b - 1), sz, (op == 2'b01) ? 2'b00 : 2'b01});
                rem -= b;
                if (op == 2'b00) cur = (cur + 64'(b * bsz)) % 64'h1_0000_0000;
            end
        end
        exp_err = ill || (errb >= 0 && errb < exp_beats);
        obs.delete();
        beat_idx = 0;
        err_beat = errb;
        @(posedge clock); #1;
        srcAddr = a; srcOp = op; srcDataWidth = sz; numOfBytes = 23'(nb);
        reqInQueue = 1; spaceWrTranQueue = 1;
        @(posedge clock); #1;
        reqInQueue = 0;
    endtask

    task automatic finish_req(input string name);
        int cyc = 0;
        bit got = 0;
        bit gd = 0, ge = 0;
        while (!got && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (rdDone || rdError) begin
                got = 1; gd = rdDone; ge = rdError;
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL %s completion timeout: got no pulse, required one within 20000 cycles", name);
        end
        total++;
        if ({gd, ge} !== (exp_err ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL %s pulse kind: done/error=%b%b, required %b", name, gd, ge, exp_err ? 2'b01 : 2'b10);
        end
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL %s AR count: got %0d, required %0d", name, obs.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (obs[i] !== exp_q[i]) begin
                    bad++; $display("FAIL %s AR[%0d] addr/len/size/burst: got %h/%h/%h/%h, required %h/%h/%h/%h",
                        name, i, obs[i][44:13], obs[i][12:5], obs[i][4:2], obs[i][1:0],
                        exp_q[i][44:13], exp_q[i][12:5], exp_q[i][4:2], exp_q[i][1:0]);
                end
            end
        end
        if (exp_beats > 0) begin
            total++;
            if (beat_idx !== exp_beats) begin
                bad++; $display("FAIL %s beats accepted: got %0d, required %0d", name, beat_idx, exp_beats);
            end
        end else begin
            total++;
            if (cyc > 2) begin
                bad++; $display("FAIL %s no-AR completion latency: got %0d cycles, required <= 2", name, cyc);
            end
        end
        exp_sel = ~exp_sel;
        @(negedge clock);
        total++;
        if ({rdCache1Sel, rdDone, rdError, busy} !== {exp_sel, 3'b000}) begin
            bad++; $display("FAIL %s after-done sel/done/err/busy: got %b, required %b", name,
                {rdCache1Sel, rdDone, rdError, busy}, {exp_sel, 3'b000});
        end
    endtask

    task automatic run_req(input string name, input logic [31:0] a, input logic [1:0] op,
                           input logic [2:0] sz, input int nb, input int errb);
        start_req(a, op, sz, nb, errb);
        finish_req(name);
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST} !== {1'b0, 32'd0, 8'd0, 3'd0, 2'b01}) begin
            bad++; $display("FAIL %s AR fields: got valid=%b addr=%h len=%h size=%h burst=%b, required 0/0/0/0/01",
                name, ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST);
        end
        total++;
        if ({rdCache1Sel, rdDone, rdError, busy} !== 4'b0000) begin
            bad++; $display("FAIL %s sel/done/err/busy: got %b, required 0000", name, {rdCache1Sel, rdDone, rdError, busy});
        end
    endtask

    task automatic test_reset();
        resetn = 0; reqInQueue = 0; spaceWrTranQueue = 0;
        srcAddr = 0; srcOp = 0; srcDataWidth = 0; numOfBytes = 0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        resetn = 1;
        exp_sel = 0;
        @(negedge clock);
        check_reset_values("reset_release");
    endtask

    task automatic test_single_burst();
        run_req("single", 32'h0000_1000, 2'b00, 3'd3, 64, -1);
    endtask

    task automatic test_4k_split();
        run_req("split4k", 32'h0000_0FF0, 2'b00, 3'd3, 64, -1);
        run_req("wrap32", 32'hFFFF_FFF0, 2'b00, 3'd3, 64, -1);
        run_req("fixed", 32'h0000_0FF8, 2'b01, 3'd3, 200, -1);
    endtask

    task automatic test_outstanding();
        int n;
        r_hold = 1; r_release = 0; max_out = 0;
        start_req(32'h0000_2000, 2'b00, 3'd3, 8192, -1);
        repeat (60) @(negedge clock);
        total++;
        if ({obs.size() == 2, ARVALID, busy} !== 3'b101) begin
            bad++; $display("FAIL outstanding hold: ARs=%0d valid=%b busy=%b, required 2/0/1", obs.size(), ARVALID, busy);
        end
        r_release = 1;
        n = 0;
        while (obs.size() < 3 && n < 3000) begin
            @(negedge clock); n++;
        end
        repeat (20) @(negedge clock);
        total++;
        if (obs.size() !== 3) begin
            bad++; $display("FAIL outstanding release: got %0d ARs, required 3", obs.size());
        end
        r_hold = 0;
        finish_req("outstanding");
        total++;
        if (max_out > MAXO) begin
            bad++; $display("FAIL outstanding limit: got %0d in flight, required <= %0d", max_out, MAXO);
        end
    endtask

    task automatic test_error_path();
        run_req("rresp_err", 32'h0000_3000, 2'b00, 3'd3, 64, 2);
    endtask

    task automatic test_illegal();
        run_req("ill_op", 32'h0000_1000, 2'b10, 3'd3, 64, -1);
        run_req("ill_align", 32'h0000_1004, 2'b00, 3'd3, 64, -1);
        run_req("ill_size", 32'h0000_1000, 2'b00, 3'd4, 64, -1);
        run_req("zero_len", 32'h0000_1000, 2'b00, 3'd3, 0, -1);
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        logic [7:0]  l0;
        ar_stall = 14;
        @(posedge clock); #1;
        start_req(32'h0000_5000, 2'b00, 3'd2, 100, -1);
        @(negedge clock);
        total++;
        if (ARVALID !== 1'b0) begin
            bad++; $display("FAIL latency early: ARVALID=%b one cycle after start, required 0", ARVALID);
        end
        @(negedge clock);
        total++;
        if (ARVALID !== 1'b1) begin
            bad++; $display("FAIL latency: ARVALID=%b two cycles after start, required 1", ARVALID);
        end
        a0 = ARADDR; l0 = ARLEN;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if ({ARVALID, ARADDR, ARLEN} !== {1'b1, a0, l0}) begin
                bad++; $display("FAIL stall hold %0d: valid/addr/len=%b/%h/%h, required 1/%h/%h", i, ARVALID, ARADDR, ARLEN, a0, l0);
            end
        end
        finish_req("stall");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  op;
            int          nb, eb;
            sz = 3'($urandom_range(0, 4));
            op = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
            a = $urandom;
            a[11:0] = 12'(12'hE00 + $urandom_range(0, 511));
            a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
            nb = $urandom_range(0, 600);
            if ($urandom_range(0, 15) == 0) nb = 0;
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : -1;
            run_req($sformatf("random%0d", i), a, op, sz, nb, eb);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        ar_stall = 10;
        @(posedge clock); #1;
        start_req(32'h0000_7000, 2'b00, 3'd3, 512, -1);
        while (!ARVALID && n < 20) begin
            @(posedge clock); #1; n++;
        end
        resetn = 0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clock);
        pend.delete(); cur_beat = 0; out_cnt = 0;
        @(posedge clock); #1;
        resetn = 1;
        exp_sel = 0;
        repeat (4) @(posedge clock);
        run_req("after_reset", 32'h0000_1000, 2'b00, 3'd3, 64, -1);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_4k_split();
        test_outstanding();
        test_error_path();
        test_illegal();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/axi4dma_rd_burst_ctrl.md
# axi4dma_rd_burst_ctrl

Read burst controller for the AXI4 DMA core. It sits directly downstream of the two-entry read transaction queue. It takes the descriptor currently presented at the queue head, splits it into AXI4 AR bursts, and tracks outstanding R bursts until the last one completes. It then signals completion or error to the error/ack logic and flips the queue read-cache select.

## Interface
- `MAX_TRAN_SIZE_WIDTH`, 23, width of the byte count.
- `AXI_DATA_WIDTH`, 64, master data bus width in bits: 32, 64, 128, 256 or 512.
- `MAX_OUTSTANDING`, 4, maximum AR bursts accepted but not yet closed by RLAST. Range 1–8.
- `clock`  in  1  core clock; all logic on posedge.
- `resetn`  in  1  asynchronous active-low reset.
- `reqInQueue`  in  1  queue holds at least one request.
- `srcAddr`  in  32  start byte address of the head request.
- `srcOp`  in  2  source operation:
  - 00 = INCR
  - 01 = FIXED
  - 1x = illegal
- `srcDataWidth`  in  3  AXSIZE code of the source beat.
- `numOfBytes`  in  MAX_TRAN_SIZE_WIDTH  transfer length in bytes.
- `spaceWrTranQueue`  in  1  downstream write queue can accept a request.
- `ARADDR`  out  32  burst address.
- `ARLEN`  out  8  beats minus one.
- `ARSIZE`  out  3  equals latched `srcDataWidth`.
- `ARBURST`  out  2  01 = INCR, 00 = FIXED.
- `ARVALID`  out  1  address valid.
- `ARREADY`  in  1  address accepted.
- `RVALID`  in  1  read beat valid; handshake owned by the data path.
- `RREADY`  in  1  observed from the data path; beat counted on `RVALID & RREADY`.
- `RLAST`  in  1  last beat of a burst.
- `RRESP`  in  2  read response.
- `rdCache1Sel`  out  1  selects which queue entry is the head.
- `rdDone`  out  1  one-cycle pulse: request completed OKAY.
- `rdError`  out  1  one-cycle pulse: request completed with error.
- `busy`  out  1  FSM not in IDLE.

## Operation
- States: IDLE, CALC, ADDR, DRAIN, DONE.
- **IDLE → CALC:** on `reqInQueue & spaceWrTranQueue`.
  - Latch `srcAddr`, `srcOp` and `srcDataWidth` into working registers.
  - Compute total beats as `ceil(numOfBytes / 2^srcDataWidth)`, 24-bit.
- **IDLE → DONE (error, no AR issued):** if any of the following hold:
  - `numOfBytes == 0` (completes as rdDone, not error)
  - `srcOp[1]` set
  - `srcDataWidth > log2(AXI_DATA_WIDTH/8)`
  - `srcAddr` not aligned to `2^srcDataWidth`
- **CALC:** compute `burstBeats` as the minimum of:
  - remaining beats
  - 256 for INCR, 16 for FIXED
  - beats to the next 4 KB boundary, INCR only (see Configuration)
  - Register `ARLEN = burstBeats - 1`, then go to ADDR.
- **ADDR:** `ARVALID` high and all AR fields stable until `ARREADY`. On the handshake:
  - remaining beats -= `burstBeats`
  - INCR: address += `burstBeats << srcDataWidth`, modulo 2^32; FIXED: address unchanged
  - outstanding count += 1
  - Next state: CALC if beats remain and outstanding < `MAX_OUTSTANDING`; otherwise DRAIN.
- **DRAIN:** return to CALC when beats remain and outstanding drops below the limit. Go to DONE when no beats remain and outstanding == 0.
- **Outstanding counter:**
  - decrements on each `RVALID & RREADY & RLAST`
  - a simultaneous AR handshake and RLAST leave it unchanged
- **Error latch:** any beat with `RRESP[1]` set sets a sticky error flag. The request still drains fully; no AR is aborted.
- **DONE:** exactly one of `rdDone`/`rdError` pulses for one cycle and `rdCache1Sel` toggles; then IDLE.

## Timing
- Reset values: `ARVALID`=0, `ARADDR`=0, `ARLEN`=0, `ARSIZE`=0, `ARBURST`=01, `rdCache1Sel`=0, `rdDone`=0, `rdError`=0, `busy`=0.
- State, counters and error flag reset to IDLE and zero.
- First `ARVALID` rises 2 cycles after the cycle in which IDLE sees the start condition.
- Each further burst costs 1 CALC cycle plus the ADDR handshake.
- Completion pulse: 1 cycle after the last RLAST; the next request may start the cycle after DONE.
- Reset asserted mid-transfer drops `ARVALID` immediately. In-flight R beats after reset are not tracked.
- AXI rule: once `ARVALID` is asserted it is not deasserted before `ARREADY`.

## Configuration
- Macro `CORE_AXI4DMA_RD_4K_SPLIT_EN`.
- **Defined:** INCR bursts never cross a 4 KB boundary; the limit is `(4096 - addr[11:0]) >> srcDataWidth` beats.
- **Undefined:** the 4 KB term is removed and bursts are limited only by length and burst type. This is for AXI3-style fabrics that handle the split; it saves the subtractor.

## Structure
- Shared package `axi4dma_rd_pkg`:
  - FSM state enum
  - ARBURST constants: `BURST_FIXED`, `BURST_INCR`
  - max-length constants (256, 16)
  - response-error decode function
- Sub-module `axi4dma_rd_burst_calc`: combinational minimum-of-limits computation (remaining beats, type limit, 4 KB limit) producing `burstBeats`; instantiated once.

## Test plan
- **Single burst:** addr 0x1000, 64 bytes, INCR, size 3 → one AR with ARLEN=7, ARADDR=0x1000; 8 beats OKAY → `rdDone` pulse, `rdCache1Sel` 0→1.
- **4 KB split:** addr 0x0FF0, 64 bytes, size 3 → ARLEN=1 at 0x0FF0, then ARLEN=5 at 0x1000. With the macro undefined → a single ARLEN=7.
- **Outstanding limit:** 8192 bytes, size 3, `MAX_OUTSTANDING`=2, RLAST withheld → exactly 2 ARs (ARLEN=255 each), FSM in DRAIN. Releasing one RLAST issues the third AR.
- **Error path:** `RRESP`=10 on beat 3 of 8 → all 8 beats accepted, then `rdError` pulse and no `rdDone`.
- **Illegal inputs:** `srcOp`=10, or addr 0x1004 with size 3 → no `ARVALID`, `rdError` 2 cycles after start. `numOfBytes`=0 → `rdDone` with no AR.
- **Stall and reset:** `ARREADY` held low 5 cycles → `ARADDR` and `ARLEN` stable throughout. `resetn` pulsed during ADDR → all outputs at reset values on the next edge.
